// File: rtl/alu_pkg.sv
// Shared op codes, skid-state encoding and flag bundle for the ALU result stage.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_NOR  = 3'b101;
  localparam logic [2:0] OP_NAND = 3'b110;
  localparam logic [2:0] OP_XNOR = 3'b111;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_t;

  typedef struct packed {
    logic carry;
    logic zero;
    logic neg;
  } alu_flags_t;

  // Only add/sub produce a meaningful bit SIZE; logic ops may leave junk there.
  function automatic logic op_has_carry(input logic [2:0] sel);
    return (sel == OP_ADD) || (sel == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_result_stage_if.sv
// Upstream ALU-result and downstream flagged-result handshakes of the result stage.
interface alu_result_stage_if #(
  parameter int SIZE  = 8,
  parameter int CNT_W = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [SIZE:0]    in_res;
  logic [2:0]       in_sel;

  logic             out_valid;
  logic             out_ready;
  logic [SIZE-1:0]  out_data;
  logic [2:0]       out_sel;
  logic             out_carry;
  logic             out_zero;
  logic             out_neg;
  logic [CNT_W-1:0] out_count;

  modport master (
    output in_valid, in_res, in_sel, out_ready,
    input  in_ready, out_valid, out_data, out_sel,
    input  out_carry, out_zero, out_neg, out_count
  );

  modport slave (
    input  in_valid, in_res, in_sel, out_ready,
    output in_ready, out_valid, out_data, out_sel,
    output out_carry, out_zero, out_neg, out_count
  );

endinterface

// File: rtl/alu_flag_gen.sv
// Combinational carry/zero/neg derivation from a raw ALU result; zero latency, no handshake.
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int SIZE = 8
) (
  input  logic [SIZE:0] i_res,
  input  logic [2:0]    i_sel,
  output alu_flags_t    o_flags
);

  always_comb begin
    o_flags       = '0;
    o_flags.carry = op_has_carry(i_sel) ? i_res[SIZE] : 1'b0;
    o_flags.zero  = (i_res[SIZE-1:0] == '0);
    o_flags.neg   = i_res[SIZE-1];
  end

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU result + flags behind a 2-entry skid buffer; 1-cycle latency, in_ready depends only on state.
// Optional ALU_RESULT_STICKY_EN adds a sticky carry flag with clear input.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int SIZE  = 8,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst,
`ifdef ALU_RESULT_STICKY_EN
  input  logic sticky_clr,
  output logic sticky_carry,
`endif
  alu_result_stage_if.slave bus
);

  typedef struct packed {
    logic [SIZE-1:0] data;
    logic [2:0]      sel;
    alu_flags_t      flags;
  } entry_t;

  skid_state_t      r_state;
  skid_state_t      w_state_nxt;
  entry_t           r_m;
  entry_t           r_s;
  entry_t           w_new;
  alu_flags_t       w_flags;
  logic [CNT_W-1:0] r_count;

  logic w_in_ready;
  logic w_out_valid;
  logic w_in_xfer;
  logic w_out_xfer;
  logic w_load_m_new;
  logic w_load_m_skid;
  logic w_load_s;

  alu_flag_gen #(.SIZE(SIZE)) u_flag_gen (
    .i_res   (bus.in_res),
    .i_sel   (bus.in_sel),
    .o_flags (w_flags)
  );

  always_comb begin
    w_new       = '0;
    w_new.data  = bus.in_res[SIZE-1:0];
    w_new.sel   = bus.in_sel;
    w_new.flags = w_flags;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_in_ready    = 1'b1;
    w_out_valid   = 1'b0;
    w_load_m_new  = 1'b0;
    w_load_m_skid = 1'b0;
    w_load_s      = 1'b0;
    w_in_xfer     = 1'b0;
    w_out_xfer    = 1'b0;

    case (r_state)
      ST_EMPTY: begin
        w_in_xfer = bus.in_valid;
        if (w_in_xfer) begin
          w_load_m_new = 1'b1;
          w_state_nxt  = ST_ONE;
        end
      end
      ST_ONE: begin
        w_out_valid = 1'b1;
        w_in_xfer   = bus.in_valid;
        w_out_xfer  = bus.out_ready;
        if (w_in_xfer && w_out_xfer) begin
          w_load_m_new = 1'b1;
        end else if (w_in_xfer) begin
          w_load_s    = 1'b1;
          w_state_nxt = ST_FULL;
        end else if (w_out_xfer) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b1;
        w_out_xfer  = bus.out_ready;
        if (w_out_xfer) begin
          w_load_m_skid = 1'b1;
          w_state_nxt   = ST_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_m     <= '0;
      r_s     <= '0;
      r_count <= '0;
    end else begin
      if (w_load_m_new) begin
        r_m <= w_new;
      end else if (w_load_m_skid) begin
        r_m <= r_s;
      end
      if (w_load_s) begin
        r_s <= w_new;
      end
      if (w_out_xfer) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

`ifdef ALU_RESULT_STICKY_EN
  logic r_sticky;

  // Clear beats a same-cycle set so software never loses a clear request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sticky <= 1'b0;
    end else if (sticky_clr) begin
      r_sticky <= 1'b0;
    end else if (w_out_xfer && r_m.flags.carry) begin
      r_sticky <= 1'b1;
    end
  end

  assign sticky_carry = r_sticky;
`endif

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = r_m.data;
  assign bus.out_sel   = r_m.sel;
  assign bus.out_carry = r_m.flags.carry;
  assign bus.out_zero  = r_m.flags.zero;
  assign bus.out_neg   = r_m.flags.neg;
  assign bus.out_count = r_count;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed-vector bench for alu_result_stage; sticky checks build when ALU_RESULT_STICKY_EN is defined.
module tb_alu_result_stage;

  logic clk;
  logic rst;
  int   n_total;
  int   n_bad;

`ifdef ALU_RESULT_STICKY_EN
  logic sticky_clr;
  logic sticky_carry;
`endif

  alu_result_stage_if #(.SIZE(8), .CNT_W(16)) bus ();

  alu_result_stage #(.SIZE(8), .CNT_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
`ifdef ALU_RESULT_STICKY_EN
    .sticky_clr   (sticky_clr),
    .sticky_carry (sticky_carry),
`endif
    .bus          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [8:0] res, input logic [2:0] sel);
    bus.in_valid = 1'b1;
    bus.in_res   = res;
    bus.in_sel   = sel;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    n_total       = 0;
    n_bad         = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_res    = '0;
    bus.in_sel    = '0;
    bus.out_ready = 1'b0;
`ifdef ALU_RESULT_STICKY_EN
    sticky_clr    = 1'b0;
`endif
    tick();
    tick();
    rst = 1'b0;

    // reset values
    check("rst_in_ready",  32'(bus.in_ready),  32'h1);
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_data",      32'(bus.out_data),  32'h0);
    check("rst_sel",       32'(bus.out_sel),   32'h0);
    check("rst_flags", 32'({bus.out_carry, bus.out_zero, bus.out_neg}), 32'h0);
    check("rst_count",     32'(bus.out_count), 32'h0);

    // add with carry out, all-zero low byte
    bus.out_ready = 1'b1;
    send(9'h100, 3'b000);
    check("t1_valid", 32'(bus.out_valid), 32'h1);
    check("t1_data",  32'(bus.out_data),  32'h00);
    check("t1_flags", 32'({bus.out_carry, bus.out_zero, bus.out_neg}), 32'b110);
    tick();
    check("t1_count", 32'(bus.out_count), 32'h1);
    check("t1_empty", 32'(bus.out_valid), 32'h0);

    // fill skid under backpressure
    bus.out_ready = 1'b0;
    send(9'h080, 3'b011);
    check("t2_ready_one", 32'(bus.in_ready), 32'h1);
    send(9'h005, 3'b000);
    check("t2_ready_full", 32'(bus.in_ready), 32'h0);
    check("t2_data",  32'(bus.out_data), 32'h80);
    check("t2_sel",   32'(bus.out_sel),  32'h3);
    check("t2_flags", 32'({bus.out_carry, bus.out_zero, bus.out_neg}), 32'b001);
    tick();
    check("t2_hold_data", 32'(bus.out_data), 32'h80);
    check("t2_hold_neg",  32'(bus.out_neg),  32'h1);
    bus.out_ready = 1'b1;
    tick();
    check("t2_second",   32'(bus.out_data),  32'h05);
    check("t2_sel2",     32'(bus.out_sel),   32'h0);
    check("t2_ready_bk", 32'(bus.in_ready),  32'h1);
    check("t2_count",    32'(bus.out_count), 32'h2);
    tick();
    check("t2_drained", 32'(bus.out_valid), 32'h0);
    check("t2_count3",  32'(bus.out_count), 32'h3);

    // 256 back-to-back results from a fresh count
    do_reset();
    check("t3_count0", 32'(bus.out_count), 32'h0);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_sel    = 3'b010;
    for (int i = 0; i < 256; i++) begin
      bus.in_res = {1'b0, i[7:0]};
      tick();
      check("t3_data", 32'(bus.out_data), 32'(i[7:0]));
      check("t3_hs",   32'({bus.out_valid, bus.in_ready}), 32'b11);
    end
    bus.in_valid = 1'b0;
    tick();
    check("t3_count", 32'(bus.out_count), 32'd256);
    check("t3_empty", 32'(bus.out_valid), 32'h0);

    // junk bit 8 on a logic op must not raise carry; sub borrow must
    bus.out_ready = 1'b0;
    send(9'h10F, 3'b010);
    check("t4_or_carry", 32'(bus.out_carry), 32'h0);
    check("t4_or_data",  32'(bus.out_data),  32'h0F);
    check("t4_or_zn",    32'({bus.out_zero, bus.out_neg}), 32'b00);
    send(9'h1FF, 3'b001);
    bus.out_ready = 1'b1;
    tick();
    check("t4_sub_data",  32'(bus.out_data), 32'hFF);
    check("t4_sub_flags", 32'({bus.out_carry, bus.out_zero, bus.out_neg}), 32'b101);
    check("t4_sub_sel",   32'(bus.out_sel),  32'h1);
    tick();

    // reset while FULL; a blocked input and a same-cycle transfer are both ignored
    bus.out_ready = 1'b0;
    send(9'h0AA, 3'b100);
    send(9'h0BB, 3'b100);
    check("t5_full", 32'(bus.in_ready), 32'h0);
    send(9'h0CC, 3'b100);
    check("t5_ignored", 32'(bus.out_data), 32'hAA);
    rst           = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_res    = 9'h0DD;
    bus.out_ready = 1'b1;
    tick();
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    check("t5_valid", 32'(bus.out_valid), 32'h0);
    check("t5_ready", 32'(bus.in_ready),  32'h1);
    check("t5_count", 32'(bus.out_count), 32'h0);
    check("t5_data",  32'(bus.out_data),  32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_no_stale", 32'(bus.out_valid), 32'h0);
    end
    send(9'h033, 3'b010);
    check("t5_fresh", 32'(bus.out_data), 32'h33);
    tick();
    check("t5_count1", 32'(bus.out_count), 32'h1);

`ifdef ALU_RESULT_STICKY_EN
    do_reset();
    check("s_rst", 32'(sticky_carry), 32'h0);
    bus.out_ready = 1'b1;
    send(9'h101, 3'b000);
    send(9'h002, 3'b010);
    send(9'h003, 3'b010);
    send(9'h004, 3'b010);
    tick();
    check("s_set", 32'(sticky_carry), 32'h1);
    send(9'h180, 3'b001);
    sticky_clr = 1'b1;
    tick();
    check("s_clr_wins", 32'(sticky_carry), 32'h0);
    sticky_clr = 1'b0;
    tick();
    check("s_stays", 32'(sticky_carry), 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
